// File: rtl/scope_pkg.sv
// scope_pkg: shared FSM state encoding and default widths for the scope capture block.
package scope_pkg;
    localparam int DATA_W_DEF = 10;
    localparam int ADDR_W_DEF = 10;
    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT_TRIG, S_POST, S_DONE} state_t;
endpackage

// File: rtl/scope_ram.sv
// scope_ram: simple dual-port sample buffer, one write port and one registered read port.
module scope_ram
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // only the read register is reset; the array itself keeps its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else if (re) rd_q <= mem[ra];
    end

    assign rd = rd_q;
endmodule

// File: rtl/scope_capture.sv
// scope_capture: triggered sample-capture buffer with pre/post-trigger windows and logical readout.
// Define SCOPE_CAPTURE_DECIM_EN to add the decim input that stores only every (decim+1)-th sample.
module scope_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pre_len,
`ifdef SCOPE_CAPTURE_DECIM_EN
    input  logic [7:0]        decim,
`endif
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_pos
);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, pre_q, pre_d;
    logic [ADDR_W-1:0] trig_pos_q, trig_pos_d, post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic prev_ok_q, prev_ok_d, rd_valid_q, rd_valid_d;
    logic capturing, keep, acc, hit, fire, pre_done;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_phys;

`ifdef SCOPE_CAPTURE_DECIM_EN
    logic [7:0] dec_cnt_q, dec_cnt_d;
    assign keep = dec_cnt_q == 8'd0;
`else
    assign keep = 1'b1;
`endif

    assign capturing  = state_q inside {S_PREFILL, S_WAIT_TRIG, S_POST};
    assign acc        = capturing && adc_valid && keep && !arm;
    assign wr_ptr_inc = wr_ptr_q + 1'b1;
    assign hit        = prev_ok_q && (trig_rising ? (prev_q < trig_level && adc_data >= trig_level)
                                                  : (prev_q > trig_level && adc_data <= trig_level));
    assign fire       = state_q == S_WAIT_TRIG && acc && hit;
    // with pre_len=0 the single PREFILL cycle still stores its sample; as the first one it cannot trigger
    assign pre_done   = pre_q == '0 || (acc && wr_ptr_inc == pre_q);
    assign rd_phys    = trig_pos_q - pre_q + rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm) state_d = S_PREFILL;
        else case (state_q)
            S_PREFILL:   if (pre_done) state_d = S_WAIT_TRIG;
            S_WAIT_TRIG: if (fire) state_d = pre_q == '1 ? S_DONE : S_POST;
            S_POST:      if (acc && post_cnt_q == ADDR_W'(1)) state_d = S_DONE;
            default:     ;
        endcase
    end

    always_comb begin
        busy = capturing;
        done = state_q == S_DONE;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        pre_d      = pre_q;
        trig_pos_d = trig_pos_q;
        post_cnt_d = post_cnt_q;
        prev_d     = prev_q;
        prev_ok_d  = prev_ok_q;
`ifdef SCOPE_CAPTURE_DECIM_EN
        dec_cnt_d  = dec_cnt_q;
`endif
        if (arm) begin
            wr_ptr_d  = '0;
            pre_d     = pre_len;
            prev_ok_d = 1'b0;
`ifdef SCOPE_CAPTURE_DECIM_EN
            dec_cnt_d = 8'd0;
`endif
        end else begin
            if (acc) begin
                wr_ptr_d  = wr_ptr_inc;
                prev_d    = adc_data;
                prev_ok_d = 1'b1;
            end
            // post-trigger length DEPTH-1-pre_len is the bitwise complement of pre_len
            if (fire) begin
                trig_pos_d = wr_ptr_q;
                post_cnt_d = ~pre_q;
            end
            if (state_q == S_POST && acc) post_cnt_d = post_cnt_q - 1'b1;
`ifdef SCOPE_CAPTURE_DECIM_EN
            if (capturing && adc_valid) dec_cnt_d = dec_cnt_q == decim ? 8'd0 : dec_cnt_q + 8'd1;
`endif
        end
        rd_valid_d = rd_en && !arm && state_q == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            pre_q      <= '0;
            trig_pos_q <= '0;
            post_cnt_q <= '0;
            prev_q     <= '0;
            prev_ok_q  <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef SCOPE_CAPTURE_DECIM_EN
            dec_cnt_q  <= 8'd0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            pre_q      <= pre_d;
            trig_pos_q <= trig_pos_d;
            post_cnt_q <= post_cnt_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            rd_valid_q <= rd_valid_d;
`ifdef SCOPE_CAPTURE_DECIM_EN
            dec_cnt_q  <= dec_cnt_d;
`endif
        end
    end

    scope_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (acc),
        .wa    (wr_ptr_q),
        .wd    (adc_data),
        .re    (rd_valid_d),
        .ra    (rd_phys),
        .rd    (rd_data)
    );

    assign trig_pos = trig_pos_q;
    assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: randomized captures checked against a sample-list model of the scope buffer.
module tb_scope_capture;
    localparam int DW = 10;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, adc_valid = 1'b0, trig_rising = 1'b1, rd_en = 1'b0;
    logic [DW-1:0] adc_data = '0, trig_level = '0;
    logic [AW-1:0] pre_len = '0, rd_addr = '0;
    logic [7:0] decim = 8'd0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] trig_pos;
    logic rd_valid, busy, done;

    int checks = 0, failures = 0;
    int st[$];
    int t_idx, f_idx, n_valid, dcnt;

    always #5 clk = ~clk;

    scope_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .pre_len     (pre_len),
`ifdef SCOPE_CAPTURE_DECIM_EN
        .decim       (decim),
`endif
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .trig_pos    (trig_pos)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit hits(int p, int c, int l, bit r);
        return r ? (p < l && c >= l) : (p > l && c <= l);
    endfunction

    // stimulus by valid-sample number n: 0 ramp, 1 noise, 2 falling table, 3 quiet then spike at 1500, 4 rising table
    function automatic int gen(int mode, int n);
        int seq_fall[4] = '{10, 30, 25, 20};
        int seq_rise[4] = '{600, 700, 400, 600};
        if (mode == 0) return n % DEPTH;
        if (mode == 2 && n < 4) return seq_fall[n];
        if (mode == 4 && n < 4) return seq_rise[n];
        if (mode == 3 && n < 1500) return int'($urandom_range(0, 499));
        if (mode == 3 && n == 1500) return 800;
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic run_capture(input int pre, input int lvl, input bit rise, input int mode,
                               input int gap, input int stop_after);
        bit v;
        int d;
        @(negedge clk);
        arm = 1'b1;
        pre_len = AW'(pre);
        trig_level = DW'(lvl);
        trig_rising = rise;
        adc_valid = 1'b0;
        rd_en = 1'b1;
        rd_addr = AW'($urandom);
        @(posedge clk);
        #1;
        check("arm_rd_valid", rd_valid, 0);
        check("arm_done", done, 0);
        check("arm_busy", busy, 1);
        st.delete();
        t_idx = -1;
        f_idx = -1;
        n_valid = 0;
        dcnt = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            arm = 1'b0;
            v = $urandom_range(0, 99) >= gap;
            rd_en = $urandom_range(0, 1) == 1;
            rd_addr = AW'($urandom);
            adc_valid = v;
            if (v) begin
                d = gen(mode, n_valid);
                n_valid++;
                adc_data = DW'(d);
                if (dcnt == 0) begin
                    if (t_idx < 0 && st.size() >= pre && st.size() >= 1 && hits(st[st.size() - 1], d, lvl, rise)) begin
                        t_idx = st.size();
                        f_idx = t_idx + DEPTH - 1 - pre;
                    end
                    st.push_back(d);
                end
                dcnt = (dcnt == int'(decim)) ? 0 : dcnt + 1;
            end
            @(posedge clk);
            #1;
            if (rd_en) check("busy_rd_valid", rd_valid, 0);
            if (stop_after > 0 && t_idx >= 0 && st.size() >= t_idx + 1 + stop_after) begin
                check("abort_done", done, 0);
                adc_valid = 1'b0;
                rd_en = 1'b0;
                return;
            end
            if (done || (t_idx >= 0 && st.size() == f_idx + 1)) begin
                check("done_at", st.size(), f_idx + 1);
                check("done", done, 1);
                check("busy_end", busy, 0);
                check("trig_pos", trig_pos, t_idx % DEPTH);
                adc_valid = 1'b0;
                rd_en = 1'b0;
                return;
            end
        end
        check("timeout_done", done, 1);
        adc_valid = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic read_at(input int a, output int v);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = AW'(a);
        @(posedge clk);
        #1;
        check("rd_valid", rd_valid, 1);
        v = int'(rd_data);
        rd_en = 1'b0;
    endtask

    task automatic read_all(input int pre);
        int v;
        int a;
        if (t_idx < 0) return;
        for (int i = 0; i < 7; i++) begin
            a = (i == 0) ? 0 : (i == 1) ? pre : (i == 2) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
            read_at(a, v);
            check("rd_data", v, st[t_idx - pre + a]);
        end
    endtask

    initial begin
        int v;
        int p;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_trig_pos", trig_pos, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_capture(100, 500, 1'b1, 0, 0, 0);
        check("ramp_trig_pos", trig_pos, 500);
        read_at(100, v);
        check("ramp_rd100", v, 500);
        read_at(0, v);
        check("ramp_rd0", v, 400);
        read_all(100);

        run_capture(0, 20, 1'b0, 2, 0, 0);
        check("fall_trig_idx", t_idx, 3);
        read_all(0);

        run_capture(0, 500, 1'b1, 4, 0, 0);
        check("first_no_trig", t_idx, 3);
        read_all(0);

        run_capture(1023, 500, 1'b1, 3, 0, 0);
        check("wrap_trig_pos", trig_pos, 1500 % DEPTH);
        read_at(1023, v);
        check("wrap_rd1023", v, 800);
        read_all(1023);

        for (int i = 0; i < 3; i++) begin
            p = int'($urandom_range(0, DEPTH - 1));
            run_capture(p, int'($urandom_range(100, 900)), $urandom_range(0, 1) == 1, 1, 30, 0);
            read_all(p);
        end

        run_capture(50, 300, 1'b1, 0, 0, 50);
        p = int'($urandom_range(0, 200));
        run_capture(p, 700, 1'b1, 0, 10, 0);
        check("rearm_trig_pos", trig_pos, 700);
        read_all(p);

`ifdef SCOPE_CAPTURE_DECIM_EN
        decim = 8'd3;
        run_capture(20, 300, 1'b1, 0, 25, 0);
        check("decim_trig_idx", t_idx, 75);
        read_at(0, v);
        check("decim_rd0", v, 220);
        read_all(20);
        decim = 8'd0;
`endif

        run_capture(50, 700, 1'b1, 0, 0, 200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_trig_pos", trig_pos, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            adc_valid = 1'b1;
            adc_data = DW'($urandom);
        end
        @(negedge clk);
        adc_valid = 1'b0;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_rd_valid", rd_valid, 0);
        rd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
